// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Included first so controller, step unit and interface agree on encodings.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Issue-side bundle of the Booth multiplier: start/operands in,
// status and product out.
interface booth_seq_multiplier_if #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  ready,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output ready,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/booth_seq_multiplier_step_unit.sv
// One radix-2 Booth iteration: conditional add/sub of M into A,
// then arithmetic shift right of {A,Q,Q_1}.
module booth_step_unit
  import mult_pkg::*;
#(
  parameter int AW = DEFAULT_WIDTH + 1
) (
  input  logic [AW-1:0] a,
  input  logic [AW-2:0] q,
  input  logic          q_1,
  input  logic [AW-1:0] m,
  output logic [AW-1:0] a_n,
  output logic [AW-2:0] q_n,
  output logic          q_1_n
);

  localparam int QW = AW - 1;

  logic [AW-1:0] sum;

  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a + ~m + AW'(1);
      default:   sum = a;
    endcase
  end

  assign a_n   = {sum[AW-1], sum[AW-1:1]};
  assign q_n   = {sum[0], q[QW-1:1]};
  assign q_1_n = q[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential Booth multiplier controller: owns operand/accumulator
// registers, the iteration counter and the IDLE/RUN/DONE FSM.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_seq_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int AW    = WIDTH + 1;

  state_e             state_q, state_d;
  logic [AW-1:0]      m_q, m_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [AW-1:0]      a_n;
  logic [WIDTH-1:0]   q_n;
  logic               q1_n;

  booth_step_unit #(
    .AW (AW)
  ) u_step (
    .a     (a_q),
    .q     (q_q),
    .q_1   (q1_q),
    .m     (m_q),
    .a_n   (a_n),
    .q_n   (q_n),
    .q_1_n (q1_n)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          a_d     = '0;
          q_d     = bus.multiplier;
          q1_d    = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      RUN: begin
        a_d   = a_n;
        q_d   = q_n;
        q1_d  = q1_n;
        cnt_d = cnt_q - CNT_W'(1);
        // Last step: capture the product directly from the step outputs.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          prod_d  = {a_n[WIDTH-1:0], q_n};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier (WIDTH=32): products, latency,
// ignored start, async reset and back-to-back issue.
module tb_booth_seq_multiplier;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  booth_seq_multiplier_if #(.WIDTH(32)) bus ();

  booth_seq_multiplier #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] m,
                        input logic [31:0] q,
                        input logic [63:0] exp);
    int busy_n;
    int guard;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    busy_n = 0;
    guard  = 0;
    while (bus.done !== 1'b1 && guard < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      guard++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " product"}, bus.product, exp);
    @(negedge clk);
    check({tag, " rbd_after"},
          64'({bus.ready, bus.busy, bus.done}), 64'b100);
    check({tag, " product_held"}, bus.product, exp);
  endtask

  initial begin
    int busy_n;
    int guard;
    int extra_done;
    int n_done;
    int last_c;

    tests            = 0;
    fails            = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    @(negedge clk);
    @(negedge clk);
    check("reset rbd", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
    check("reset product", bus.product, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("-7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("6x-7", 32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("min_x_min", 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000);
    run_op("min_x_1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

    // start pulsed mid-RUN must be ignored
    bus.start        = 1'b1;
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign busy", 64'(bus.busy), 64'd1);
    busy_n = 0;
    guard  = 0;
    while (bus.done !== 1'b1 && guard < 100) begin
      busy_n++;
      guard++;
      @(negedge clk);
    end
    check("ign remaining_busy", 64'(busy_n), 64'd26);
    check("ign product", bus.product, 64'd8);
    extra_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra_done++;
    end
    check("ign no_second_done", 64'(extra_done), 64'd0);
    check("ign ready", 64'(bus.ready), 64'd1);

    // asynchronous reset in the middle of an operation
    bus.start        = 1'b1;
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst rbd", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
    check("arst product", bus.product, 64'd0);
    @(negedge clk);
    check("arst held product", bus.product, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // back-to-back with start held high
    bus.start        = 1'b1;
    bus.multiplicand = 32'h7FFF_FFFF;
    bus.multiplier   = 32'h7FFF_FFFF;
    n_done = 0;
    last_c = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("b2b product", bus.product, 64'h3FFF_FFFF_0000_0001);
        if (n_done > 0) check("b2b interval", 64'(c - last_c), 64'd34);
        last_c = c;
        n_done++;
      end
    end
    bus.start = 1'b0;
    check("b2b done_count", 64'(n_done), 64'd3);
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    check("b2b drain ready", 64'(bus.ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Sequential radix-2 Booth multiplier controller: one combinational Booth step datapath, iterated WIDTH times under an FSM.
- Accepts a signed multiplicand and multiplier on a start pulse and produces the full-width signed product.
- Sits between the CPU/ALU issue logic and the Booth step datapath, sharing one adder/subtractor across all iterations instead of an unrolled array.

Parameters:
- WIDTH, 32, operand width in bits (two's complement); must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- multiplicand  input  WIDTH  signed M, captured on accepted start
- multiplier  input  WIDTH  signed Q, captured on accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse, product valid
- product  output  2*WIDTH  signed result {A,Q}, held until next accepted start

Behaviour:
- Reset is asynchronous, active-high, on one clock clk. While rst=1: state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. If start=1 at an edge, load:
  - M_reg = multiplicand, sign-extended to WIDTH+1.
  - A = 0 (WIDTH+1 bits).
  - Q = multiplier.
  - Q_1 = 0.
  - count = WIDTH.
  - Go to RUN.
- RUN: busy=1. Each edge applies one Booth step:
  - {Q[0],Q_1}=01: A += M_reg.
  - 10: A -= M_reg (A + ~M_reg + 1).
  - 00/11: A unchanged.
  - Then arithmetic shift right of {A,Q,Q_1} by 1: A MSB replicated, A LSB → Q MSB, Q LSB → Q_1.
  - count decrements. On the edge where count goes 1→0, go to DONE.
- DONE: done=1 for exactly one cycle, product = {A[WIDTH-1:0], Q}. Next edge → IDLE unconditionally.
- Latency: start accepted at edge E0. Steps occur at edges E1..E_WIDTH. done is high in the cycle after E_WIDTH, so it is visible WIDTH+1 cycles after start sampling. ready returns one cycle after done.
- Width rule: the accumulator is WIDTH+1 bits so multiplicand = −2^(WIDTH−1) is exact; the extra bit is dropped only at product formation. All internal add/sub wrap modulo 2^(WIDTH+1).
- start while ready=0 (RUN or DONE): ignored, no queueing. Operand inputs are don't-care outside the accepting edge.
- product register updates only on the DONE-entry edge. It keeps its value through IDLE and the next RUN until the next DONE.
- Reset mid-operation: immediate return to IDLE, partial result discarded, product cleared to 0, no done pulse.
- Back-to-back: start asserted in the IDLE cycle right after DONE is accepted, giving a minimum issue interval of WIDTH+2 cycles.
- ready, busy and done are mutually exclusive and decoded directly from the state register. No combinational path from start to any output.

Decomposition:
- Shared package (mult_pkg):
  - State enum {IDLE, RUN, DONE} (2-bit encoding).
  - Booth decode constants BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
  - Default WIDTH.
- One sub-module: booth_step_unit, purely combinational, parameterized on accumulator width WIDTH+1.
  - Inputs: A, Q, Q_1, M.
  - Outputs: next A, Q, Q_1.
- The controller owns all registers, the counter and the FSM.

Test Plan:
- WIDTH=32. M=3, Q=5, pulse start → done after 33 cycles, product=0x0000_0000_0000_000F. busy high for exactly 32 cycles.
- M=−7 (0xFFFF_FFF9), Q=6 → product=0xFFFF_FFFF_FFFF_FFD6 (−42). Repeat with M=6, Q=−7 → same result.
- M=Q=0x8000_0000 → product=0x4000_0000_0000_0000. Then M=0x8000_0000, Q=1 → 0xFFFF_FFFF_8000_0000. Checks the extended accumulator.
- During RUN, pulse start with M=9, Q=9 → ignored: the in-flight result (M=2, Q=4 → 8) completes unchanged, no second done.
- Assert rst asynchronously (mid-cycle) at step 10 → ready=1, busy=0, product=0 immediately. A new start with M=−1, Q=−1 → product=1.
- Back-to-back: start held high continuously with M=0x7FFF_FFFF, Q=0x7FFF_FFFF → product=0x3FFF_FFFF_0000_0001 and done pulses every 34 cycles.
